audio_sequencer: RTL

AUDIO_SEQUENCER -- requirements
Module: audio_sequencer

---
 rtl/audio_sequencer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/audio_sequencer.sv
// Note sequencer: plays {half-period, duration} entries from a small memory as a square wave.
// Latency: start sampled in IDLE -> LOAD next cycle -> PLAY; every output is a flop.
// No backpressure: writes accepted every cycle; start ignored while busy; stop always wins.
// Build option: define AUDIO_SEQ_LOOP_EN to let i_loop restart the sequence instead of finishing.
module audio_sequencer #(
  parameter  int DEPTH    = 16,
  parameter  int PER_W    = 24,
  parameter  int DUR_W    = 16,
  parameter  int TICK_DIV = 12000,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [PER_W-1:0] i_wr_period,
  input  logic [DUR_W-1:0] i_wr_dur,
  input  logic [AW:0]      i_len,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_loop,
  output logic             o_pulse,
  output logic             o_busy,
  output logic             o_done,
  output logic [AW-1:0]    o_note_idx
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

`ifdef AUDIO_SEQ_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [AW:0]      len_q, len_d;
  logic [PER_W-1:0] per_q, per_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [PER_W-1:0] tone_q, tone_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [PER_W-1:0] per_mem [DEPTH];
  logic [DUR_W-1:0] dur_mem [DEPTH];

  logic [PER_W-1:0] per_rd;
  logic [DUR_W-1:0] dur_rd;
  logic             loop_req;
  logic             is_last;
  logic             tick_wrap;
  logic             note_fin;
  logic [AW-1:0]    next_idx;
  state_t           adv_state;

  // Asynchronous read: a LOAD that coincides with a write to the same entry sees the old contents.
  assign per_rd    = per_mem[idx_q];
  assign dur_rd    = dur_mem[idx_q];
  assign loop_req  = LOOP_EN & i_loop;
  assign is_last   = ({1'b0, idx_q} == (len_q - (AW+1)'(1)));
  assign tick_wrap = (tick_q == TW'(TICK_DIV - 1));
  // A note finishes either at LOAD (zero duration, skipped) or on the tick that exhausts it.
  assign note_fin  = ((state_q == S_LOAD) && (dur_rd == '0)) ||
                     ((state_q == S_PLAY) && tick_wrap && (dur_q == DUR_W'(1)));
  assign adv_state = (is_last && !loop_req) ? S_DONE : S_LOAD;
  // Index holds on the final note so DONE/IDLE still report the last note played.
  assign next_idx  = is_last ? (loop_req ? '0 : idx_q) : (idx_q + AW'(1));

  // Note memory: writable in any state, never reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      per_mem[i_wr_addr] <= i_wr_period;
      dur_mem[i_wr_addr] <= i_wr_dur;
    end
  end

  // State register and registered datapath/outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      per_q   <= '0;
      dur_q   <= '0;
      tone_q  <= '0;
      tick_q  <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      per_q   <= per_d;
      dur_q   <= dur_d;
      tone_q  <= tone_d;
      tick_q  <= tick_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state decision; stop overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_start && (i_len != '0)) state_d = S_LOAD;
      S_LOAD:  state_d = note_fin ? adv_state : S_PLAY;
      S_PLAY:  if (note_fin) state_d = adv_state;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (i_stop) state_d = S_IDLE;
  end

  // Datapath and output values for the next cycle.
  always_comb begin
    idx_d   = idx_q;
    len_d   = len_q;
    per_d   = per_q;
    dur_d   = dur_q;
    tone_d  = tone_q;
    tick_d  = tick_q;
    pulse_d = pulse_q;
    case (state_q)
      S_IDLE: begin
        if (i_start && (i_len != '0)) begin
          idx_d   = '0;
          len_d   = (i_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : i_len;
          pulse_d = 1'b0;
        end
      end
      S_LOAD: begin
        per_d   = per_rd;
        dur_d   = dur_rd;
        tone_d  = '0;
        tick_d  = '0;
        pulse_d = 1'b0;
        if (note_fin) idx_d = next_idx;
      end
      S_PLAY: begin
        if (per_q == '0) begin
          tone_d  = '0;
          pulse_d = 1'b0;
        end else if (tone_q == (per_q - PER_W'(1))) begin
          tone_d  = '0;
          pulse_d = ~pulse_q;
        end else begin
          tone_d  = tone_q + PER_W'(1);
        end
        if (tick_wrap) begin
          tick_d = '0;
          dur_d  = dur_q - DUR_W'(1);
        end else begin
          tick_d = tick_q + TW'(1);
        end
        // Each note starts silent, so the final half-cycle is cut at the note boundary.
        if (note_fin) begin
          pulse_d = 1'b0;
          idx_d   = next_idx;
        end
      end
      S_DONE:  pulse_d = 1'b0;
      default: pulse_d = 1'b0;
    endcase
    if (i_stop) begin
      pulse_d = 1'b0;
      idx_d   = '0;
    end
    busy_d = (state_d == S_LOAD) || (state_d == S_PLAY);
    done_d = (state_d == S_DONE);
  end

  assign o_pulse    = pulse_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_note_idx = idx_q;

endmodule
